// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control stage in front of the BCD mm:ss time counter. It conditions three
//   raw push-buttons, runs the stopwatch state machine, and divides CLK1 down
//   to a one-cycle-per-second count pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped, time cleared; prescaler held at 0
//   RUN   | counting; prescaler advances every cycle
//   PAUSE | stopped, time kept; prescaler holds its value
//   LAP   | counting continues, display frozen (lap_hold)
//
// Ports
//   CLK1           in   system clock
//   RESET          in   asynchronous, active-high reset
//   btn_start_stop in   raw start/stop button (async, active-high)
//   btn_clear      in   raw clear button (async, active-high)
//   btn_lap        in   raw lap button (async, active-high)
//   enable         out  one-cycle count pulse, once per TICKS_PER_SEC cycles
//   clear_req      out  one-cycle request to zero the stored time
//   running        out  high in RUN or LAP
//   lap_hold       out  high in LAP
//   state          out  IDLE=00, RUN=01, PAUSE=10, LAP=11
module stopwatch_ctrl #(
  parameter int TICKS_PER_SEC   = 1000,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       CLK1,
  input  logic       RESET,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       enable,
  output logic       clear_req,
  output logic       running,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  // Button index: 0 = start_stop, 1 = clear, 2 = lap
  logic [2:0]         raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         level;
  logic [2:0][DW-1:0] db_cnt;
  logic [2:0]         press;

  state_t        st;
  state_t        st_nxt;
  logic [PW-1:0] presc;
  logic          presc_zero;
  logic          clr_go;
  logic          go_clr;
  logic          go_ss;
  logic          go_lap;

  assign raw = {btn_lap, btn_clear, btn_start_stop};

  // Synchronizer and debounce. The press strobe is the condition that makes
  // the debounced level rise, so the FSM acts on the same edge the level
  // toggles; releases never strobe.
  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      sync1  <= '0;
      sync2  <= '0;
      level  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= ~level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    press = '0;
    for (int i = 0; i < 3; i++) begin
      press[i] = sync2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
    end
  end

  // Priority select: only the highest-priority press survives a collision,
  // even if the current state then ignores it.
  assign go_clr = press[1];
  assign go_ss  = press[0] & ~press[1];
  assign go_lap = press[2] & ~press[1] & ~press[0];

  // State register
  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      st <= S_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    st_nxt     = st;
    presc_zero = 1'b0;
    clr_go     = 1'b0;
    case (st)
      S_IDLE: begin
        if (go_clr) begin
          clr_go = 1'b1;
        end else if (go_ss) begin
          st_nxt     = S_RUN;
          presc_zero = 1'b1;
        end
      end
      S_RUN: begin
        if (go_ss) begin
          st_nxt = S_PAUSE;
        end else if (go_lap) begin
          st_nxt = S_LAP;
        end
      end
      S_LAP: begin
        if (go_ss) begin
          st_nxt = S_PAUSE;
        end else if (go_lap) begin
          st_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (go_clr) begin
          st_nxt     = S_IDLE;
          presc_zero = 1'b1;
          clr_go     = 1'b1;
        end else if (go_ss) begin
          st_nxt = S_RUN;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // Prescaler advances on the current state, so the edge leaving RUN/LAP
  // still increments (and wraps on a terminal tick).
  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      presc     <= '0;
      clear_req <= 1'b0;
    end else begin
      clear_req <= clr_go;
      if (st == S_IDLE || presc_zero) begin
        presc <= '0;
      end else if (st == S_RUN || st == S_LAP) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      end
    end
  end

  // Output decode, registers only
  always_comb begin
    running  = (st == S_RUN) || (st == S_LAP);
    lap_hold = (st == S_LAP);
    enable   = running && (presc == PRESC_LAST);
  end

  assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Scoreboard bench for stopwatch_ctrl with TICKS_PER_SEC=10 and
//   DEBOUNCE_CYCLES=4. Expected enable / clear_req cycles are queued when a
//   button is driven and consumed by a negedge monitor.
module tb_stopwatch_ctrl;
  localparam int TPS = 10;
  localparam int DBC = 4;
  localparam int LAT = 2 + DBC;   // raw rise to acting edge

  logic       CLK1 = 1'b0;
  logic       RESET = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic       enable;
  logic       clear_req;
  logic       running;
  logic       lap_hold;
  logic [1:0] state;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  int en_q[$];
  int clr_q[$];

  stopwatch_ctrl #(.TICKS_PER_SEC(TPS), .DEBOUNCE_CYCLES(DBC)) dut (
    .CLK1           (CLK1),
    .RESET          (RESET),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .enable         (enable),
    .clear_req      (clear_req),
    .running        (running),
    .lap_hold       (lap_hold),
    .state          (state)
  );

  always #5 CLK1 = ~CLK1;
  always @(posedge CLK1) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_state(input string tag, input int exp_st);
    check_eq({tag, "_state"}, int'(state), exp_st);
    check_eq({tag, "_running"}, int'(running), (exp_st == 1 || exp_st == 3) ? 1 : 0);
    check_eq({tag, "_lap_hold"}, int'(lap_hold), (exp_st == 3) ? 1 : 0);
  endtask

  // Advance to 1 time unit after posedge number c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK1);
      #1;
    end
  endtask

  always @(negedge CLK1) begin
    if (!RESET) begin
      while (en_q.size() > 0 && en_q[0] < cyc) begin
        check_eq("enable_missed", cyc, en_q[0]);
        void'(en_q.pop_front());
      end
      if (enable) begin
        if (en_q.size() > 0) check_eq("enable_cycle", cyc, en_q.pop_front());
        else check_eq("enable_unexpected", int'(enable), 0);
      end
      while (clr_q.size() > 0 && clr_q[0] < cyc) begin
        check_eq("clear_req_missed", cyc, clr_q[0]);
        void'(clr_q.pop_front());
      end
      if (clear_req) begin
        if (clr_q.size() > 0) check_eq("clear_req_cycle", cyc, clr_q.pop_front());
        else check_eq("clear_req_unexpected", int'(clear_req), 0);
      end
    end
  end

  initial begin
    int t, h, r1, e0, r3, ep, r4, er, r5, r6, r7, ep2, r8, ec, r9, e, r10, rr;

    // Reset state
    goto(2);
    check_eq("rst_enable", int'(enable), 0);
    check_eq("rst_clear_req", int'(clear_req), 0);
    check_state("rst", 0);
    goto(3);
    RESET = 1'b0;

    // Clear bounce (3 high / 3 low) then a stable hold while IDLE
    t = 10;
    goto(t);
    for (int i = 0; i < 4; i++) begin
      btn_clear = 1'b1;
      goto(t + 3);
      btn_clear = 1'b0;
      goto(t + 6);
      t = t + 6;
    end
    h = t;
    btn_clear = 1'b1;
    clr_q.push_back(h + LAT);
    goto(h + LAT);
    check_state("clr_idle", 0);
    goto(h + 10);
    btn_clear = 1'b0;

    // Clean start_stop: IDLE -> RUN, first enable 9 edges later, period 10
    r1 = h + 20;
    goto(r1);
    btn_start_stop = 1'b1;
    e0 = r1 + LAT;
    for (int k = 0; k < 3; k++) en_q.push_back(e0 + TPS - 1 + k * TPS);
    goto(e0 - 1);
    check_state("start_pre", 0);
    goto(e0);
    check_state("start_run", 1);
    goto(r1 + 8);
    btn_start_stop = 1'b0;

    // Pause when prescaler is 5 (it holds at 6), then resume
    r3 = e0 + 30;
    goto(r3);
    btn_start_stop = 1'b1;
    ep = r3 + LAT;
    goto(ep);
    check_state("pause", 2);
    goto(r3 + 8);
    btn_start_stop = 1'b0;
    r4 = r3 + 20;
    goto(r4);
    btn_start_stop = 1'b1;
    er = r4 + LAT;
    for (int k = 0; k < 7; k++) en_q.push_back(er + 3 + k * TPS);
    goto(er - 1);
    check_state("resume_pre", 2);
    goto(er);
    check_state("resume", 1);
    goto(r4 + 8);
    btn_start_stop = 1'b0;

    // Lap in and out; enable cadence must not change
    r5 = r4 + 20;
    goto(r5);
    btn_lap = 1'b1;
    goto(r5 + LAT);
    check_state("lap_in", 3);
    goto(r5 + 8);
    btn_lap = 1'b0;
    r6 = r5 + 16;
    goto(r6);
    btn_lap = 1'b1;
    goto(r6 + LAT);
    check_state("lap_out", 1);
    goto(r6 + 8);
    btn_lap = 1'b0;

    // Stop on the terminal tick: that enable still counts
    r7 = er + 58;
    ep2 = r7 + LAT;
    goto(r7);
    btn_start_stop = 1'b1;
    goto(ep2 - 1);
    check_eq("terminal_enable", int'(enable), 1);
    goto(ep2);
    check_state("terminal_pause", 2);
    check_eq("pause_enable", int'(enable), 0);
    goto(r7 + 8);
    btn_start_stop = 1'b0;

    // Clear and start_stop together in PAUSE: clear wins
    r8 = ep2 + 12;
    goto(r8);
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    ec = r8 + LAT;
    clr_q.push_back(ec);
    goto(ec);
    check_state("coinc_idle", 0);
    goto(ec + 4);
    check_state("coinc_stay", 0);
    goto(r8 + 8);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;

    // Restart (prescaler must start from 0), enter LAP, reset at prescaler 7
    r9 = r8 + 20;
    goto(r9);
    btn_start_stop = 1'b1;
    e = r9 + LAT;
    en_q.push_back(e + 9);
    en_q.push_back(e + 19);
    goto(e + 9);
    check_eq("restart_enable", int'(enable), 1);
    goto(r9 + 8);
    btn_start_stop = 1'b0;
    r10 = r9 + 20;
    goto(r10);
    btn_lap = 1'b1;
    goto(r10 + LAT);
    check_state("lap2", 3);
    goto(r10 + 8);
    btn_lap = 1'b0;
    goto(e + 27);
    #2;
    btn_start_stop = 1'b1;   // held through reset
    RESET = 1'b1;
    #1;
    check_eq("async_rst_enable", int'(enable), 0);
    check_eq("async_rst_clear_req", int'(clear_req), 0);
    check_state("async_rst", 0);
    rr = e + 30;
    goto(rr);
    RESET = 1'b0;
    en_q.push_back(rr + LAT + TPS - 1);
    en_q.push_back(rr + LAT + 2 * TPS - 1);
    goto(rr + LAT - 1);
    check_state("held_pre", 0);
    check_eq("held_pre_enable", int'(enable), 0);
    goto(rr + LAT);
    check_state("held_run", 1);
    goto(rr + 8);
    btn_start_stop = 1'b0;
    goto(rr + 27);
    RESET = 1'b1;
    goto(rr + 30);

    check_eq("enable_queue_left", en_q.size(), 0);
    check_eq("clear_req_queue_left", clr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
